// File: rtl/mem_dma_pkg.sv
// Shared types and default widths for the mem_dma word-copy engine.
package mem_dma_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_dma_ptr.sv
// Loadable, incrementing address pointer that wraps modulo 2^W.
// The upcoming value is exported so the caller can register it onto a bus
// in the same edge that updates the pointer.
module mem_dma_ptr #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_inc,
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_next
);

  logic [W-1:0] ptr_q;

  // Next pointer value: load wins over increment; natural overflow gives the wrap.
  always_comb begin
    // NOTE: default assignment first so every path assigns o_next and no latch is inferred.
    o_next = ptr_q;
    if (i_load) begin
      o_next = i_value;
    end else if (i_inc) begin
      o_next = ptr_q + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= o_next;
    end
  end

endmodule

// File: rtl/mem_dma.sv
// mem_dma: single-channel word copy engine (READ/WRITE ping-pong, 2 cycles per word).
// Optional build macro MEM_DMA_FILL_EN adds a pattern-fill mode (1 cycle per word)
// with extra ports i_fill and i_pattern latched together with i_start.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [LEN_W-1:0]  i_len,
`ifdef MEM_DMA_FILL_EN
  input  logic              i_fill,
  input  logic [DATA_W-1:0] i_pattern,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  input  logic [DATA_W-1:0] i_data
);

  state_e            state;
  logic [LEN_W-1:0]  cnt_q;
  logic              fill_q;
  logic [DATA_W-1:0] pattern_q;
  logic              fill_sel;
  logic [DATA_W-1:0] pattern_sel;
  logic              ptr_load;
  logic              ptr_inc;
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dst_next;

  // Fill-mode request; tied off when the feature is not built.
  always_comb begin
`ifdef MEM_DMA_FILL_EN
    fill_sel    = i_fill;
    pattern_sel = i_pattern;
`else
    fill_sel    = 1'b0;
    pattern_sel = '0;
`endif
  end

  // Pointers load on an accepted start and advance together after every write.
  assign ptr_load = (state == ST_IDLE) && i_start;
  assign ptr_inc  = (state == ST_WRITE);

  mem_dma_ptr #(.W(ADDR_W)) u_src_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (ptr_load),
    .i_inc   (ptr_inc),
    .i_value (i_src),
    .o_next  (src_next)
  );

  mem_dma_ptr #(.W(ADDR_W)) u_dst_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (ptr_load),
    .i_inc   (ptr_inc),
    .i_value (i_dst),
    .o_next  (dst_next)
  );

  // Control FSM; bus outputs are registered for the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: the async reset clears every output register too, so the bus is quiet the moment i_rst_n falls.
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      cnt_q     <= '0;
      fill_q    <= 1'b0;
      pattern_q <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_mem_rd  <= 1'b0;
      o_mem_wr  <= 1'b0;
      o_address <= '0;
      o_data    <= '0;
    end else begin
      // NOTE: outputs are non-blocking and default low here, so each branch only names what it raises.
      o_done   <= 1'b0;
      o_mem_rd <= 1'b0;
      o_mem_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            cnt_q     <= i_len;
            fill_q    <= fill_sel;
            pattern_q <= pattern_sel;
            o_busy    <= 1'b1;
            if (i_len == '0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else if (fill_sel) begin
              state     <= ST_WRITE;
              o_mem_wr  <= 1'b1;
              o_address <= dst_next;
              o_data    <= pattern_sel;
            end else begin
              state     <= ST_READ;
              o_mem_rd  <= 1'b1;
              o_address <= src_next;
            end
          end
        end
        ST_READ: begin
          if (i_abort) begin
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            o_address <= '0;
          end else begin
            // o_data doubles as the word buffer between READ and WRITE.
            state     <= ST_WRITE;
            o_mem_wr  <= 1'b1;
            o_address <= dst_next;
            o_data    <= i_data;
          end
        end
        ST_WRITE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
          if (i_abort) begin
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            o_address <= '0;
          end else if (cnt_q <= LEN_W'(1)) begin
            state     <= ST_DONE;
            o_done    <= 1'b1;
            o_address <= '0;
          end else if (fill_q) begin
            o_mem_wr  <= 1'b1;
            o_address <= dst_next;
            o_data    <= pattern_q;
          end else begin
            state     <= ST_READ;
            o_mem_rd  <= 1'b1;
            o_address <= src_next;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          o_busy    <= 1'b0;
          o_address <= '0;
        end
        default: begin
          state     <= ST_IDLE;
          o_busy    <= 1'b0;
          o_address <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: table vectors, hand sequences and random
// transfers scored against a word-level copy model and cycle-count arithmetic.
module tb_mem_dma;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_abort;
  logic [15:0] i_src;
  logic [15:0] i_dst;
  logic [15:0] i_len;
`ifdef MEM_DMA_FILL_EN
  logic        i_fill;
  logic [15:0] i_pattern;
`endif
  logic        o_busy;
  logic        o_done;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [15:0] o_address;
  logic [15:0] o_data;
  logic [15:0] i_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  mem_dma dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .i_src     (i_src),
    .i_dst     (i_dst),
    .i_len     (i_len),
`ifdef MEM_DMA_FILL_EN
    .i_fill    (i_fill),
    .i_pattern (i_pattern),
`endif
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_mem_rd  (o_mem_rd),
    .o_mem_wr  (o_mem_wr),
    .o_address (o_address),
    .o_data    (o_data),
    .i_data    (i_data)
  );

  // Memory: untouched words read a fixed background pattern.
  logic [15:0] mem     [0:65535];
  bit          written [0:65535];
  logic [15:0] exp_mem [0:65535];

  function automatic logic [15:0] init_val(input int unsigned a);
    if (a >= 32'h10 && a <= 32'h13) return 16'(16'h1111 * (a - 32'h0f));
    return 16'(a * 40503 + 4660);
  endfunction

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    return written[a] ? mem[a] : init_val(a);
  endfunction

  assign i_data = rd_mem(o_address);

  always @(posedge i_clk) begin
    if (o_mem_wr) begin
      mem[o_address]     <= o_data;
      written[o_address] <= 1'b1;
    end
  end

  typedef struct {
    int          done_cyc;
    int          n_done;
    int          nrd;
    int          nwr;
    int          idle_cyc;
    bit          excl_err;
    bit          seq_err;
    logic [15:0] idle_addr;
  } res_t;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    int          abort_at;
    int          exp_done;
    int          exp_rd;
    int          exp_wr;
    int          exp_idle;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timing/strobe expectation from the transfer rules: copy costs 2 cycles per
  // word, fill 1; abort at cycle k stops after the words whose write cycle <= k.
  function automatic res_t model(input int len, input int abort_at, input bit fill);
    res_t e;
    int   last;
    e = '{default: 0};
    last = fill ? len : 2 * len;
    if (abort_at >= 1 && abort_at <= last) begin
      e.nwr      = fill ? abort_at : abort_at / 2;
      e.nrd      = fill ? 0 : (abort_at + 1) / 2;
      e.idle_cyc = abort_at + 1;
    end else begin
      e.nwr      = len;
      e.nrd      = fill ? 0 : len;
      e.done_cyc = last + 1;
      e.n_done   = 1;
      e.idle_cyc = last + 2;
    end
    return e;
  endfunction

  // Ascending word-by-word copy (or fill) of the first nwr words.
  task automatic apply_model(input logic [15:0] src, input logic [15:0] dst, input int nwr,
                             input bit fill, input logic [15:0] pat);
    for (int i = 0; i < nwr; i++) begin
      exp_mem[16'(dst + 16'(i))] = fill ? pat : exp_mem[16'(src + 16'(i))];
    end
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int a = 0; a < 65536; a++) begin
      if (rd_mem(16'(a)) !== exp_mem[a]) bad++;
    end
    check({tag, ".mem_bad_words"}, 64'(bad), 64'd0);
  endtask

  task automatic run_xfer(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                          input int abort_at, input int junk_at, input bit fill,
                          input logic [15:0] pat, output res_t r);
    int cyc = 1;
    int ridx = 0;
    r = '{default: 0};
    i_src = src;
    i_dst = dst;
    i_len = len;
`ifdef MEM_DMA_FILL_EN
    i_fill    = fill;
    i_pattern = pat;
`endif
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    while (1) begin
      if (o_mem_rd && o_mem_wr) r.excl_err = 1'b1;
      if (o_mem_rd) begin
        if (o_address !== 16'(src + 16'(ridx))) r.seq_err = 1'b1;
        ridx++;
        r.nrd++;
      end
      if (o_mem_wr) r.nwr++;
      if (o_done) begin
        r.n_done++;
        r.done_cyc = cyc;
      end
      if (!o_busy) begin
        r.idle_cyc  = cyc;
        r.idle_addr = o_address;
        break;
      end
      if (cyc >= 200) begin
        r.idle_cyc = -1;
        break;
      end
      i_abort = (cyc == abort_at);
      if (cyc == junk_at) begin
        i_start = 1'b1;
        i_src   = 16'($urandom);
        i_dst   = 16'($urandom);
        i_len   = 16'($urandom_range(1, 9));
`ifdef MEM_DMA_FILL_EN
        i_fill    = ~fill;
        i_pattern = 16'($urandom);
`endif
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_abort = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic compare_res(input string tag, input res_t a, input res_t e);
    check({tag, ".done_cycle"}, 64'(a.done_cyc), 64'(e.done_cyc));
    check({tag, ".done_pulses"}, 64'(a.n_done), 64'(e.n_done));
    check({tag, ".reads"}, 64'(a.nrd), 64'(e.nrd));
    check({tag, ".writes"}, 64'(a.nwr), 64'(e.nwr));
    check({tag, ".idle_cycle"}, 64'(a.idle_cyc), 64'(e.idle_cyc));
    check({tag, ".rd_wr_overlap"}, 64'(a.excl_err), 64'd0);
    check({tag, ".read_order"}, 64'(a.seq_err), 64'd0);
    check({tag, ".idle_address"}, 64'(a.idle_addr), 64'd0);
  endtask

  vec_t vecs [10];

  initial begin
    res_t r;
    res_t e;
    bit   quiet;
    for (int a = 0; a < 65536; a++) exp_mem[a] = init_val(a);

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_src   = '0;
    i_dst   = '0;
    i_len   = '0;
`ifdef MEM_DMA_FILL_EN
    i_fill    = 1'b0;
    i_pattern = '0;
`endif
    repeat (2) @(negedge i_clk);
    check("reset_outputs", {o_busy, o_done, o_mem_rd, o_mem_wr, o_address, o_data}, '0);
    i_rst_n = 1'b1;
    i_abort = 1'b1;
    @(negedge i_clk);
    check("idle_abort_ignored", {o_busy, o_done, o_mem_rd, o_mem_wr, o_address}, '0);
    i_abort = 1'b0;

    //            src       dst       len  abort done rd wr idle
    vecs[0] = '{16'h0010, 16'h0200, 16'd4, 0, 9, 4, 4, 10};
    vecs[1] = '{16'hfffe, 16'h0100, 16'd3, 0, 7, 3, 3, 8};
    vecs[2] = '{16'h0000, 16'h0500, 16'd0, 0, 1, 0, 0, 2};
    vecs[3] = '{16'h0020, 16'h0600, 16'd4, 3, 0, 2, 1, 4};
    vecs[4] = '{16'h0030, 16'h0610, 16'd4, 2, 0, 1, 1, 3};
    vecs[5] = '{16'h0040, 16'h0620, 16'd3, 1, 0, 1, 0, 2};
    vecs[6] = '{16'h0050, 16'h0630, 16'd1, 0, 3, 1, 1, 4};
    vecs[7] = '{16'h0000, 16'h0640, 16'd0, 1, 1, 0, 0, 2};
    vecs[8] = '{16'h0060, 16'h0650, 16'd2, 5, 5, 2, 2, 6};
    vecs[9] = '{16'h0070, 16'h0072, 16'd5, 0, 11, 5, 5, 12};

    for (int v = 0; v < 10; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_xfer(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].abort_at, 0, 1'b0, 16'h0, r);
      e = '{default: 0};
      e.done_cyc = vecs[v].exp_done;
      e.n_done   = (vecs[v].exp_done != 0) ? 1 : 0;
      e.nrd      = vecs[v].exp_rd;
      e.nwr      = vecs[v].exp_wr;
      e.idle_cyc = vecs[v].exp_idle;
      compare_res(tag, r, e);
      apply_model(vecs[v].src, vecs[v].dst, vecs[v].exp_wr, 1'b0, 16'h0);
      if (v == 0) begin
        for (int i = 0; i < 4; i++) begin
          check($sformatf("vec0.dst_word%0d", i), 64'(rd_mem(16'(16'h0200 + 16'(i)))),
                64'(16'h1111 * (i + 1)));
        end
        check("vec0.o_data_held", 64'(o_data), 64'h4444);
      end
      check_mem(tag);
    end

    // Start pulsed while busy must not disturb the running transfer.
    run_xfer(16'h0080, 16'h0660, 16'd2, 0, 2, 1'b0, 16'h0, r);
    compare_res("busy_start", r, model(2, 0, 1'b0));
    apply_model(16'h0080, 16'h0660, 2, 1'b0, 16'h0);
    check_mem("busy_start");

    // Reset during WRITE, after an ignored start while busy.
    i_src   = 16'h0090;
    i_dst   = 16'h0670;
    i_len   = 16'd4;
    i_start = 1'b1;
    @(negedge i_clk);
    i_src   = 16'h0999;
    i_len   = 16'd7;
    @(negedge i_clk);
    i_start = 1'b0;
    check("rst_seq.in_write", {o_busy, o_mem_rd, o_mem_wr}, 3'b101);
    i_rst_n = 1'b0;
    #1;
    check("rst_seq.async_clear", {o_busy, o_done, o_mem_rd, o_mem_wr, o_address, o_data}, '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge i_clk);
      if (o_busy || o_done || o_mem_rd || o_mem_wr) quiet = 1'b0;
    end
    check("rst_seq.quiet_after_release", 64'(quiet), 64'd1);
    check_mem("rst_seq");

`ifdef MEM_DMA_FILL_EN
    run_xfer(16'h0000, 16'h0300, 16'd3, 0, 0, 1'b1, 16'hbeef, r);
    compare_res("fill", r, model(3, 0, 1'b1));
    apply_model(16'h0000, 16'h0300, 3, 1'b1, 16'hbeef);
    check("fill.word2", 64'(rd_mem(16'h0302)), 64'hbeef);
    check_mem("fill");
`endif

    for (int t = 0; t < 24; t++) begin
      logic [15:0] src;
      logic [15:0] dst;
      int          len;
      int          ab;
      int          junk;
      bit          fill;
      logic [15:0] pat;
      string       tag;
      tag  = $sformatf("rnd%0d", t);
      len  = $urandom_range(0, 8);
      src  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65530, 65535)) : 16'($urandom_range(0, 63));
      dst  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65530, 65535)) : 16'($urandom_range(0, 63));
      ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * len + 1) : 0;
      junk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len + 1) : 0;
      pat  = 16'($urandom);
`ifdef MEM_DMA_FILL_EN
      fill = 1'($urandom_range(0, 1));
`else
      fill = 1'b0;
`endif
      run_xfer(src, dst, 16'(len), ab, junk, fill, pat, r);
      e = model(len, ab, fill);
      compare_res(tag, r, e);
      apply_model(src, dst, e.nwr, fill, pat);
      check_mem(tag);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
